aura_mem_responder: RTL and testbench
=====================================

# aura_mem_responder

Synthesizable responder for the AURA main-memory command protocol; it sits on the memory side of `memory_controller`. It accepts one command per cycle on `proc2mem_*` and returns a transaction tag for each accepted load. Load data comes back later, tagged, on `mem2proc_*`. With jitter enabled it returns out of order, which exercises the controller's tag matching and serves as the bench and FPGA memory model.

## Interface
- `MEM_LATENCY`, 4: base cycles from load acceptance to data return; must be ≥1.
- `JITTER_MASK`, 0: extra per-load delay is `lfsr & JITTER_MASK`; must be 2^k−1 with k ≤ 3.
- `DEPTH`, 1024: number of 64-bit blocks in storage.
- `NUM_TAGS`, 15: maximum outstanding loads; tags are 1..NUM_TAGS.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `proc2mem_command`, input, MEM_COMMAND: NONE, LOAD or STORE.
- `proc2mem_addr`, input, ADDR (32): byte address. Bits [2:0] are ignored.
- `proc2mem_data`, input, MEM_BLOCK (64): store data.
- `mem2proc_transaction_tag`, output, MEM_TAG (4): tag for the current cycle's load; 0 means not accepted.
- `mem2proc_data`, output, MEM_BLOCK (64): returned load data.
- `mem2proc_data_tag`, output, MEM_TAG (4): tag of `mem2proc_data`; 0 means no return this cycle.

## Operation
- **Block index.** `idx = addr[31:3]`. The address is in range when `idx < DEPTH`.
- **`mem2proc_transaction_tag`** is combinational in the same cycle as the command. It is nonzero only for an accepted LOAD. It is 0 for NONE, for STORE, and for a LOAD that is rejected.
- **STORE.**
  - Always accepted.
  - Storage is written at the clock edge ending the cycle.
  - An out-of-range STORE is dropped silently.
  - A STORE never occupies a tag.
- **LOAD acceptance.**
  - A LOAD is accepted if any table entry is free. It receives the lowest free tag.
  - When all NUM_TAGS entries are busy, the LOAD is rejected with tag 0. Nothing is recorded, and the controller must retry.
- **LOAD data capture.**
  - Data is read from storage at acceptance, not at return. A later STORE to the same block does not alter an outstanding load.
  - An out-of-range LOAD returns 64'h0.
- **Outstanding table.** Per tag, the table holds `valid`, captured data and a countdown.
  - On acceptance, countdown = `MEM_LATENCY − 1 + (lfsr & JITTER_MASK)`.
  - Each cycle, nonzero countdowns decrement.
  - An entry with `valid` and countdown 0 is eligible.
- **Return arbitration.**
  - Each cycle, the lowest-numbered eligible tag is registered onto `mem2proc_data_tag` / `mem2proc_data`, and its entry is freed at that same edge.
  - Other eligible entries stay at 0 and wait.
  - If nothing is eligible, the data tag is 0 and the data holds its last value.
- **Tag reuse.** A tag freed at edge E is allocatable in the cycle following E, never in the cycle that drives its return.
- **LFSR.**
  - 8-bit Galois, taps x^8+x^6+x^5+x^4+1, seeded 8'h01 at reset.
  - Advances only on an accepted LOAD, after its delay has been sampled.
  - It must never reach 0.
- **Storage.**
  - Not cleared by reset.
  - The bench may preload it hierarchically before releasing reset.

## Timing
- **Reset (`rst` = 0).**
  - Outputs: `mem2proc_data_tag` = 0, `mem2proc_data` = 0, `mem2proc_transaction_tag` = 0 regardless of inputs.
  - Internal state: all entries invalid, LFSR = 8'h01.
- **Reset mid-operation.** All outstanding loads are discarded with no return. The first LOAD after reset gets tag 1.
- **Load return latency.** A LOAD accepted in cycle t with zero jitter returns with data tag = its tag during cycle t+MEM_LATENCY, provided no lower tag is also eligible.
- **Arbitration delay.** A return blocked by arbitration slips by one cycle per lower-tag winner.
- **Store-to-load.** A STORE in cycle t is visible to a LOAD in cycle t+1.
- **Throughput.** At most one acceptance and one return per cycle.
- **Sustained loads.** With `JITTER_MASK` = 0 and loads every cycle, returns are in order, one per cycle, with no collisions. Full occurs only if MEM_LATENCY > NUM_TAGS.

## Test plan
- **Reset:** hold `rst` low 3 cycles with LOAD driven → all three outputs read 0 throughout; release → the next LOAD gets tag 1.
- **Store then load:** STORE 64'hDEADBEEF_CAFEF00D to 0x100 in cycle 5, LOAD 0x100 in cycle 6 → transaction tag 1 in cycle 6; data tag 1 with that data in cycle 10 (MEM_LATENCY = 4).
- **Full:** with MEM_LATENCY = 20, issue 16 consecutive LOADs → tags 1..15, then 0. The first return frees tag 1, and the next LOAD gets tag 1 one cycle later.
- **Jitter and collision:** with `JITTER_MASK` = 3, issue 8 loads to distinct preloaded blocks → every tag returns exactly once, with correct data, none earlier than MEM_LATENCY, and at most one return per cycle.
- **Capture and out-of-range:** LOAD 0x200 then STORE new data to 0x200 before the return → the old data is returned. LOAD `(DEPTH*8)` → 64'h0. A STORE there leaves storage unchanged.
- **Reset mid-flight:** 5 loads outstanding, pulse `rst` → no data tag is asserted afterward, and the next LOAD gets tag 1.

Source files
------------

// File: rtl/aura_mem_responder_if.sv
// Bus bundle between memory_controller (master) and aura_mem_responder (slave).
//
// Handshake: a command is presented whenever proc2mem_command is not NONE; the
// responder has no stall input. A LOAD is taken in the same cycle exactly when
// mem2proc_transaction_tag is nonzero, otherwise the master must retry. STOREs
// are always taken. Returned data is valid in any cycle where mem2proc_data_tag
// is nonzero, and the master must consume it in that cycle (no backpressure).
interface aura_mem_responder_if;
    logic [1:0]  proc2mem_command;          // 0 = NONE, 1 = LOAD, 2 = STORE
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_transaction_tag;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_data_tag;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
    );
endinterface

// File: rtl/aura_mem_responder.sv
// AURA main-memory responder: block storage, tagged load table with optional
// LFSR jitter, and a lowest-tag-first return arbiter (one return per cycle).
module aura_mem_responder #(
    parameter int MEM_LATENCY = 4,    // >= 1
    parameter int JITTER_MASK = 0,    // 0, 1, 3 or 7
    parameter int DEPTH       = 1024, // 64-bit blocks
    parameter int NUM_TAGS    = 15    // tags 1..NUM_TAGS, at most 15
) (
    input  logic                clk,
    input  logic                rst,  // asynchronous, active-low
    aura_mem_responder_if.slave bus
);
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MEM_LATENCY + 8);
    localparam logic [2:0]       JMASK    = 3'(JITTER_MASK);
    localparam logic [CNT_W-1:0] BASE_DLY = CNT_W'(MEM_LATENCY - 1);

    // Storage is deliberately not reset.
    logic [63:0] mem_q [DEPTH];

    // Outstanding-load table, entry i holds tag i+1.
    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [63:0]         ent_data_q [NUM_TAGS];
    logic [63:0]         ent_data_d [NUM_TAGS];
    logic [CNT_W-1:0]    cnt_q [NUM_TAGS];
    logic [CNT_W-1:0]    cnt_d [NUM_TAGS];

    logic [7:0]  lfsr_q, lfsr_d;
    logic [3:0]  data_tag_q, data_tag_d;
    logic [63:0] data_q, data_d;

    logic [28:0]         blk;
    logic [IDX_W-1:0]    idx;
    logic                in_range;
    logic [63:0]         rd_data;
    logic                is_load, is_store;
    logic                have_free;
    logic [3:0]          alloc_idx;
    logic                accept;
    logic [CNT_W-1:0]    delay, new_cnt;
    logic                bypass;
    logic [NUM_TAGS-1:0] elig;
    logic                win_any;
    logic [3:0]          win_idx;
    logic [7:0]          lfsr_next;
    logic                unused_addr_bits;

    assign blk      = bus.proc2mem_addr[31:3];
    assign idx      = blk[IDX_W-1:0];
    assign in_range = ({3'b000, blk} < 32'(DEPTH));
    assign rd_data  = in_range ? mem_q[idx] : 64'h0;
    assign is_load  = (bus.proc2mem_command == CMD_LOAD);
    assign is_store = (bus.proc2mem_command == CMD_STORE);
    assign unused_addr_bits = ^{bus.proc2mem_addr[2:0], blk[28:IDX_W]};

    // Lowest free table entry supplies the tag for an incoming LOAD.
    always_comb begin
        have_free = 1'b0;
        alloc_idx = 4'd0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                have_free = 1'b1;
                alloc_idx = 4'(i);
            end
        end
    end

    assign accept = is_load && have_free;

    // Jitter is sampled from the current LFSR value before it advances. The
    // stored countdown already includes this cycle's decrement; a total delay
    // of zero means the load competes for return in its own acceptance cycle.
    assign delay   = BASE_DLY + CNT_W'(lfsr_q[2:0] & JMASK);
    assign new_cnt = (delay == '0) ? '0 : delay - CNT_W'(1);
    assign bypass  = accept && (delay == '0);

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1 (toggle mask 8'hB8);
    // maximal length, so a nonzero seed never reaches 0.
    assign lfsr_next = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

    // Entries with an expired countdown that may return this cycle.
    always_comb begin
        for (int i = 0; i < NUM_TAGS; i++) begin
            elig[i] = (valid_q[i] && (cnt_q[i] == '0)) ||
                      (bypass && (alloc_idx == 4'(i)));
        end
    end

    // Fixed priority: the lowest eligible tag wins the return slot.
    always_comb begin
        win_any = 1'b0;
        win_idx = 4'd0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_any = 1'b1;
                win_idx = 4'(i);
            end
        end
    end

    // Next-state for the table, LFSR and registered return port.
    always_comb begin
        valid_d    = valid_q;
        lfsr_d     = lfsr_q;
        data_tag_d = 4'd0;
        data_d     = data_q;
        for (int i = 0; i < NUM_TAGS; i++) begin
            ent_data_d[i] = ent_data_q[i];
            cnt_d[i]      = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
        end
        if (accept) begin
            valid_d[alloc_idx]    = 1'b1;
            ent_data_d[alloc_idx] = rd_data;
            cnt_d[alloc_idx]      = new_cnt;
            lfsr_d                = lfsr_next;
        end
        // The winner is freed at the same edge that drives its return, so
        // its tag only becomes allocatable in the following cycle.
        if (win_any) begin
            valid_d[win_idx] = 1'b0;
            data_tag_d       = win_idx + 4'd1;
            data_d           = (bypass && (win_idx == alloc_idx)) ? rd_data
                                                                  : ent_data_q[win_idx];
        end
    end

    // State registers; reset discards every outstanding load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            lfsr_q     <= 8'h01;
            data_tag_q <= 4'd0;
            data_q     <= 64'h0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                ent_data_q[i] <= 64'h0;
                cnt_q[i]      <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            lfsr_q     <= lfsr_d;
            data_tag_q <= data_tag_d;
            data_q     <= data_d;
            for (int i = 0; i < NUM_TAGS; i++) begin
                ent_data_q[i] <= ent_data_d[i];
                cnt_q[i]      <= cnt_d[i];
            end
        end
    end

    // Block storage write; out-of-range stores are dropped.
    always_ff @(posedge clk) begin
        if (is_store && in_range) begin
            mem_q[idx] <= bus.proc2mem_data;
        end
    end

    assign bus.mem2proc_transaction_tag = (rst && accept) ? alloc_idx + 4'd1 : 4'd0;
    assign bus.mem2proc_data_tag        = data_tag_q;
    assign bus.mem2proc_data            = data_q;
endmodule

// File: tb/tb_aura_mem_responder.sv
// Directed bench for aura_mem_responder: three instances (default, long
// latency, jitter) share one command stream; a per-cycle return monitor
// compares the selected instance against an expected-return queue.
module tb_aura_mem_responder;
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;
    localparam logic [63:0] DEAD = 64'hDEADBEEF_CAFEF00D;

    logic        clk;
    logic        rst;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] wdata;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int base;
    logic [83:0] exp_q[$];   // {cycle[15:0], tag[3:0], data[63:0]}
    logic        mon_en;
    int          mon_sel;
    logic [3:0]  obs_tag;
    logic [63:0] obs_data;

    // Jitter scenario, hand-derived: LFSR 01,B8,5C,2E,17,B3,E1,C8 gives
    // delays 4,3,3,5,6,6,4,3 cycles; tags reuse as entries free up.
    int j_ttag [8] = '{1, 2, 3, 4, 5, 1, 2, 3};
    int j_rcyc [8] = '{5, 6, 7, 9, 11, 12, 13, 14};
    int j_rtag [8] = '{1, 2, 3, 4, 2, 1, 3, 5};
    int j_rk   [8] = '{0, 1, 2, 3, 6, 5, 7, 4};

    aura_mem_responder_if if_a ();
    aura_mem_responder_if if_b ();
    aura_mem_responder_if if_c ();

    assign if_a.proc2mem_command = cmd;
    assign if_a.proc2mem_addr    = addr;
    assign if_a.proc2mem_data    = wdata;
    assign if_b.proc2mem_command = cmd;
    assign if_b.proc2mem_addr    = addr;
    assign if_b.proc2mem_data    = wdata;
    assign if_c.proc2mem_command = cmd;
    assign if_c.proc2mem_addr    = addr;
    assign if_c.proc2mem_data    = wdata;

    aura_mem_responder #(.MEM_LATENCY(4), .JITTER_MASK(0)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    aura_mem_responder #(.MEM_LATENCY(20), .JITTER_MASK(0)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    aura_mem_responder #(.MEM_LATENCY(4), .JITTER_MASK(3)) u_c (.clk(clk), .rst(rst), .bus(if_c));

    always_comb begin
        obs_tag  = if_a.mem2proc_data_tag;
        obs_data = if_a.mem2proc_data;
        if (mon_sel == 1) begin
            obs_tag  = if_b.mem2proc_data_tag;
            obs_data = if_b.mem2proc_data;
        end else if (mon_sel == 2) begin
            obs_tag  = if_c.mem2proc_data_tag;
            obs_data = if_c.mem2proc_data;
        end
    end

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] jval(input int k);
        return 64'hC0DE_5A5A_0000_0000 + 64'(k) * 64'h0000_0000_0101_0101;
    endfunction

    task automatic push_ret(input int c, input int t, input logic [63:0] d);
        exp_q.push_back({16'(c), 4'(t), d});
    endtask

    task automatic monitor();
        logic [83:0] e;
        if (exp_q.size() != 0 && exp_q[0][83:68] == 16'(cyc)) begin
            e = exp_q.pop_front();
            check("ret_tag", 64'(obs_tag), 64'(e[67:64]));
            check("ret_data", obs_data, e[63:0]);
        end else begin
            check("idle_tag", 64'(obs_tag), 64'h0);
        end
    endtask

    // Drive one cycle's command, then sample mid-cycle.
    task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
        @(posedge clk);
        #2;
        cmd   = c;
        addr  = a;
        wdata = d;
        cyc++;
        #1;
        if (mon_en) monitor();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        cmd = CMD_NONE;
        cyc++;
        @(posedge clk);
        #2;
        cyc++;
        rst = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        cmd     = CMD_NONE;
        addr    = 32'h0;
        wdata   = 64'h0;
        mon_en  = 1'b0;
        mon_sel = 0;
        #1 rst = 1'b0;

        // Reset held with LOAD driven: every output stays 0.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2;
            cmd  = CMD_LOAD;
            addr = 32'h100;
            cyc++;
            #1;
            check("rst_ttag", 64'(if_a.mem2proc_transaction_tag), 64'h0);
            check("rst_dtag", 64'(if_a.mem2proc_data_tag), 64'h0);
            check("rst_data", if_a.mem2proc_data, 64'h0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        cmd = CMD_NONE;
        cyc++;
        step(CMD_LOAD, 32'h100, 64'h0);
        check("first_ttag", 64'(if_a.mem2proc_transaction_tag), 64'd1);

        // Store then load, latency 4.
        do_reset();
        mon_sel = 0;
        mon_en  = 1'b1;
        step(CMD_STORE, 32'h100, DEAD);
        check("st_ttag", 64'(if_a.mem2proc_transaction_tag), 64'h0);
        step(CMD_LOAD, 32'h100, 64'h0);
        check("ld_ttag", 64'(if_a.mem2proc_transaction_tag), 64'd1);
        push_ret(cyc + 4, 1, DEAD);
        repeat (5) step(CMD_NONE, 32'h0, 64'h0);
        check("hold_data", if_a.mem2proc_data, DEAD);
        check("sb_empty_sl", 64'(exp_q.size()), 64'h0);

        // Capture at acceptance, out-of-range load/store, tag reuse.
        do_reset();
        mon_en = 1'b1;
        step(CMD_STORE, 32'h0, 64'h0D0D_0D0D_0D0D_0D0D);
        step(CMD_STORE, 32'h200, 64'hAAAA_0000_AAAA_0001);
        step(CMD_LOAD, 32'h200, 64'h0);
        check("cap_ttag1", 64'(if_a.mem2proc_transaction_tag), 64'd1);
        push_ret(cyc + 4, 1, 64'hAAAA_0000_AAAA_0001);
        step(CMD_STORE, 32'h200, 64'hBBBB_0000_BBBB_0002);
        check("cap_st_ttag", 64'(if_a.mem2proc_transaction_tag), 64'h0);
        step(CMD_LOAD, 32'h2000, 64'h0);
        check("oor_ttag", 64'(if_a.mem2proc_transaction_tag), 64'd2);
        push_ret(cyc + 4, 2, 64'h0);
        step(CMD_STORE, 32'h2000, 64'hCCCC_0000_CCCC_0003);
        step(CMD_LOAD, 32'h200, 64'h0);
        check("reuse_ttag", 64'(if_a.mem2proc_transaction_tag), 64'd1);
        push_ret(cyc + 4, 1, 64'hBBBB_0000_BBBB_0002);
        step(CMD_LOAD, 32'h0, 64'h0);
        check("blk0_ttag", 64'(if_a.mem2proc_transaction_tag), 64'd3);
        push_ret(cyc + 4, 3, 64'h0D0D_0D0D_0D0D_0D0D);
        repeat (6) step(CMD_NONE, 32'h0, 64'h0);
        check("sb_empty_cap", 64'(exp_q.size()), 64'h0);

        // Full table with latency 20.
        do_reset();
        mon_sel = 1;
        mon_en  = 1'b1;
        base    = cyc + 1;
        push_ret(base + 20, 1, DEAD);
        push_ret(base + 21, 2, DEAD);
        for (int k = 0; k < 22; k++) begin
            step(CMD_LOAD, 32'h100, 64'h0);
            check("full_ttag", 64'(if_b.mem2proc_transaction_tag),
                  (k < 15) ? 64'(k + 1) : (k < 20) ? 64'h0 : (k == 20) ? 64'd1 : 64'd2);
        end
        mon_en = 1'b0;
        check("sb_empty_full", 64'(exp_q.size()), 64'h0);

        // Reset with five loads in flight.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(CMD_LOAD, 32'h100, 64'h0);
            check("mid_ttag", 64'(if_b.mem2proc_transaction_tag), 64'(k + 1));
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        cmd = CMD_NONE;
        cyc++;
        #1;
        check("mid_rst_dtag", 64'(if_b.mem2proc_data_tag), 64'h0);
        check("mid_rst_data", if_b.mem2proc_data, 64'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        cyc++;
        mon_sel = 1;
        mon_en  = 1'b1;
        repeat (24) step(CMD_NONE, 32'h0, 64'h0);
        step(CMD_LOAD, 32'h100, 64'h0);
        check("post_rst_ttag", 64'(if_b.mem2proc_transaction_tag), 64'd1);
        mon_en = 1'b0;

        // Jitter and return collisions.
        do_reset();
        for (int k = 0; k < 8; k++) step(CMD_STORE, (32'h40 + 32'(k)) << 3, jval(k));
        mon_sel = 2;
        base    = cyc + 1;
        for (int r = 0; r < 8; r++) push_ret(base + j_rcyc[r], j_rtag[r], jval(j_rk[r]));
        mon_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(CMD_LOAD, (32'h40 + 32'(k)) << 3, 64'h0);
            check("jit_ttag", 64'(if_c.mem2proc_transaction_tag), 64'(j_ttag[k]));
        end
        repeat (10) step(CMD_NONE, 32'h0, 64'h0);
        mon_en = 1'b0;
        check("sb_empty_jit", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
